// File: rtl/seq_mul_pkg.sv
// Shared definitions for the sequential shift-add / Booth multiplier.
package seq_mul_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int unsigned DEFAULT_WIDTH = 16;

    function automatic int unsigned cnt_width(input int unsigned width);
        return $clog2(width + 1);
    endfunction

    localparam int unsigned CNT_W = cnt_width(DEFAULT_WIDTH);

    // Booth pair is {current multiplier LSB, previously shifted-out bit}
    localparam logic [1:0] BOOTH_NOP_00 = 2'b00;
    localparam logic [1:0] BOOTH_ADD    = 2'b01;
    localparam logic [1:0] BOOTH_SUB    = 2'b10;
    localparam logic [1:0] BOOTH_NOP_11 = 2'b11;

endpackage

// File: rtl/seq_mul_if.sv
// Request/response bundle between a multiplier client and seq_mul.
interface seq_mul_if #(
    parameter int unsigned WIDTH = 16
);
    logic                 start;
    logic                 is_signed;
    logic [WIDTH-1:0]     M;
    logic [WIDTH-1:0]     Q;
    logic [2*WIDTH-1:0]   result;
    logic                 busy;
    logic                 done;

    modport master (
        output start, is_signed, M, Q,
        input  result, busy, done
    );

    modport slave (
        input  start, is_signed, M, Q,
        output result, busy, done
    );
endinterface

// File: rtl/seq_mul_booth_step.sv
// One multiply iteration: conditional add/subtract of M into the upper partial, then a 1-bit shift.
module booth_step
    import seq_mul_pkg::*;
#(
    parameter int unsigned WIDTH     = 16,
    parameter bit          SIGNED_EN = 1'b1
) (
    input  logic [WIDTH:0]   i_acc,
    input  logic [WIDTH-1:0] i_q,
    input  logic             i_prev,
    input  logic [WIDTH-1:0] i_m,
    input  logic             i_signed,
    output logic [WIDTH:0]   o_acc,
    output logic [WIDTH-1:0] o_q,
    output logic             o_prev
);
    logic             w_signed;
    logic [WIDTH:0]   w_m_ext;
    logic [WIDTH:0]   w_sum;
    logic             w_fill;

    assign w_signed = SIGNED_EN && i_signed;
    assign w_m_ext  = w_signed ? {i_m[WIDTH-1], i_m} : {1'b0, i_m};

    always_comb begin
        w_sum = i_acc;
        if (w_signed) begin
            case ({i_q[0], i_prev})
                BOOTH_ADD: w_sum = i_acc + w_m_ext;
                BOOTH_SUB: w_sum = i_acc - w_m_ext;
                default:   w_sum = i_acc;
            endcase
        end else if (i_q[0]) begin
            // upper bit of i_acc is always 0 here, so the carry lands in bit WIDTH
            w_sum = i_acc + w_m_ext;
        end
    end

    assign w_fill = w_signed ? w_sum[WIDTH] : 1'b0;
    assign o_acc  = {w_fill, w_sum[WIDTH:1]};
    assign o_q    = {w_sum[0], i_q[WIDTH-1:1]};
    assign o_prev = i_q[0];

endmodule

// File: rtl/seq_mul.sv
// Sequential WIDTH x WIDTH multiplier: IDLE -> CALC (WIDTH iterations) -> DONE (one-cycle result pulse).
module seq_mul
    import seq_mul_pkg::*;
#(
    parameter int unsigned WIDTH     = 16,
    parameter bit          SIGNED_EN = 1'b1
) (
    input  logic      clk,
    input  logic      n_rst,
    seq_mul_if.slave  bus
);
    localparam int unsigned     CW        = cnt_width(WIDTH);
    localparam logic [CW-1:0]   LAST_ITER = CW'(WIDTH - 1);

    state_e                r_state;
    state_e                w_next;
    logic [WIDTH:0]        r_acc;
    logic [WIDTH-1:0]      r_q;
    logic                  r_prev;
    logic [WIDTH-1:0]      r_m;
    logic                  r_signed;
    logic [CW-1:0]         r_cnt;
    logic [2*WIDTH-1:0]    r_result;

    logic [WIDTH:0]        w_acc_n;
    logic [WIDTH-1:0]      w_q_n;
    logic                  w_prev_n;
    logic                  w_busy;
    logic                  w_done;

    booth_step #(
        .WIDTH     (WIDTH),
        .SIGNED_EN (SIGNED_EN)
    ) u_step (
        .i_acc    (r_acc),
        .i_q      (r_q),
        .i_prev   (r_prev),
        .i_m      (r_m),
        .i_signed (r_signed),
        .o_acc    (w_acc_n),
        .o_q      (w_q_n),
        .o_prev   (w_prev_n)
    );

    always_comb begin
        w_next = r_state;
        w_busy = 1'b0;
        w_done = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.start) w_next = ST_CALC;
            end
            ST_CALC: begin
                w_busy = 1'b1;
                if (r_cnt == LAST_ITER) w_next = ST_DONE;
            end
            ST_DONE: begin
                w_done = 1'b1;
                w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state  <= ST_IDLE;
            r_acc    <= '0;
            r_q      <= '0;
            r_prev   <= 1'b0;
            r_m      <= '0;
            r_signed <= 1'b0;
            r_cnt    <= '0;
            r_result <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        r_m      <= bus.M;
                        r_q      <= bus.Q;
                        r_signed <= bus.is_signed & SIGNED_EN;
                        r_acc    <= '0;
                        r_prev   <= 1'b0;
                        r_cnt    <= '0;
                    end
                end
                ST_CALC: begin
                    r_acc  <= w_acc_n;
                    r_q    <= w_q_n;
                    r_prev <= w_prev_n;
                    r_cnt  <= r_cnt + CW'(1);
                    // the final iteration's output goes straight into result on the edge entering DONE
                    if (r_cnt == LAST_ITER) r_result <= {w_acc_n[WIDTH-1:0], w_q_n};
                end
                default: ;
            endcase
        end
    end

    assign bus.result = r_result;
    assign bus.busy   = w_busy;
    assign bus.done   = w_done;

endmodule
